// File: rtl/audio_pkg.sv
// Shared audio constants for the I2S output path: default sample width and
// the I2S framing polarities used by the transmitter.
package audio_pkg;

    localparam int   AUDIO_WIDTH = 16;

    // lrclk level while the left slot is on the wire; right slot is the inverse.
    localparam logic LRCLK_LEFT  = 1'b0;
    localparam logic LRCLK_RIGHT = 1'b1;

    // Samples leave the shift register MSB first.
    localparam bit   MSB_FIRST   = 1'b1;

endpackage

// File: rtl/i2s_bclk_generator.sv
// I2S bit-clock generator: divides clk down to sclk and flags the clk cycle
// on which sclk is about to rise or fall, so the frame logic can act on the
// same clk edge that moves sclk.
module i2s_bclk_generator #(
    parameter int bclk_div = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int              DIV_W    = (bclk_div > 1) ? $clog2(bclk_div) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap      = (div_cnt == DIV_LAST);
    assign sclk_rise = wrap & ~sclk;
    assign sclk_fall = wrap &  sclk;

    // Half-period counter; sclk toggles on the wrap cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
            if (wrap) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/i2s_frame_transmitter.sv
// I2S master transmitter. Buffers one left/right pair from the upstream
// serializer and launches it atomically at the start of a frame. A frame that
// starts without a complete pair goes out silent and raises a one-clk
// underrun pulse; any half-pair already held waits for the next frame.
module i2s_frame_transmitter
    import audio_pkg::*;
#(
    parameter int audio_width = AUDIO_WIDTH,
    parameter int slot_width  = 32,
    parameter int bclk_div    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_is_left,
    input  logic [audio_width-1:0] i_audio,
    output logic                   sclk,
    output logic                   lrclk,
    output logic                   sdata,
    output logic                   o_underrun
);

    localparam int               FRAME_BITS = 2 * slot_width;
    localparam int               CNT_W      = $clog2(FRAME_BITS);
    localparam int               PAD        = slot_width - audio_width;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST  = CNT_W'(slot_width - 1);

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [audio_width-1:0] left_q;
    logic [audio_width-1:0] right_q;
    logic                   left_full;
    logic                   right_full;
    logic                   pair_ready;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       next_bit;
    logic                   frame_start;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [slot_width-1:0]  left_slot;
    logic [slot_width-1:0]  right_slot;

    i2s_bclk_generator #(
        .bclk_div (bclk_div)
    ) u_bclk (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    // Samples sit MSB-aligned in their slot with zero padding below.
    assign left_slot   = slot_width'(left_q)  << PAD;
    assign right_slot  = slot_width'(right_q) << PAD;

    assign pair_ready  = left_full & right_full;
    assign next_bit    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
    assign frame_start = sclk_fall && (next_bit == '0);

    // Ready depends only on the tag presented, so a stalled left never blocks a right.
    assign i_ready = i_is_left ? ~left_full : ~right_full;

    // Pair buffer: a load empties both halves; acceptance cannot coincide with a load
    // because a load needs both flags set, which holds i_ready low for either tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_q     <= '0;
            right_q    <= '0;
            left_full  <= 1'b0;
            right_full <= 1'b0;
        end else if (frame_start && pair_ready) begin
            left_full  <= 1'b0;
            right_full <= 1'b0;
        end else if (i_valid && i_ready) begin
            if (i_is_left) begin
                left_q    <= i_audio;
                left_full <= 1'b1;
            end else begin
                right_q    <= i_audio;
                right_full <= 1'b1;
            end
        end
    end

    // Bit counter, word select and serial data all advance on falling sclk so the
    // receiver sees stable lrclk/sdata on the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= LAST_BIT;
            shift_q    <= '0;
            lrclk      <= LRCLK_LEFT;
            sdata      <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= 1'b0;
            if (sclk_fall) begin
                bit_cnt <= next_bit;
                // lrclk switches one bit early: it leads each slot's MSB by one sclk.
                if (next_bit == LEFT_LAST) begin
                    lrclk <= LRCLK_RIGHT;
                end else if (next_bit == LAST_BIT) begin
                    lrclk <= LRCLK_LEFT;
                end
                if (next_bit == '0) begin
                    if (pair_ready) begin
                        shift_q <= {left_slot, right_slot};
                        sdata   <= left_slot[slot_width-1];
                    end else begin
                        shift_q    <= '0;
                        sdata      <= 1'b0;
                        o_underrun <= 1'b1;
                    end
                end else begin
                    shift_q <= shift_q << 1;
                    sdata   <= shift_q[FRAME_BITS-2];
                end
            end
        end
    end

    // The divider can never announce a rise and a fall in the same cycle.
    assert property (@(posedge clk) disable iff (!reset_n) !(sclk_rise && sclk_fall));

endmodule

// File: tb/tb_i2s_frame_transmitter.sv
// Scoreboard bench for i2s_frame_transmitter. A frame-level model decides at
// every frame boundary whether a complete pair is available and queues the
// expected frame; a monitor decodes sdata/lrclk on rising sclk and compares.
module tb_i2s_frame_transmitter;

    localparam int AW          = 16;
    localparam int SW          = 16;
    localparam int BD          = 2;
    localparam int FRAME_BITS  = 2 * SW;
    localparam int FRAME_CLKS  = FRAME_BITS * 2 * BD;
    localparam int FIRST_FALL  = 2 * BD;

    typedef struct packed {
        logic [AW-1:0] l;
        logic [AW-1:0] r;
        logic          uf;
    } frame_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic          i_is_left = 1'b1;
    logic [AW-1:0] i_audio = '0;
    logic          sclk, lrclk, sdata, o_underrun;

    logic          v12 = 1'b0;
    logic          rdy12;
    logic          t12 = 1'b1;
    logic [11:0]   a12 = '0;
    logic          sclk12, lrclk12, sdata12, uf12;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     running = 1'b0;
    frame_t exp_q[$];
    int     frames_checked = 0;

    always #5 clk = ~clk;

    i2s_frame_transmitter #(.audio_width(AW), .slot_width(SW), .bclk_div(BD)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_is_left(i_is_left), .i_audio(i_audio), .sclk(sclk), .lrclk(lrclk),
        .sdata(sdata), .o_underrun(o_underrun)
    );

    i2s_frame_transmitter #(.audio_width(12), .slot_width(16), .bclk_div(2)) dut12 (
        .clk(clk), .reset_n(reset_n), .i_valid(v12), .i_ready(rdy12),
        .i_is_left(t12), .i_audio(a12), .sclk(sclk12), .lrclk(lrclk12),
        .sdata(sdata12), .o_underrun(uf12)
    );

    // clk edges since reset release
    always @(posedge clk) cyc <= running ? cyc + 1 : 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // lrclk is high from the last left bit up to, but not including, the last right bit
    function automatic logic [FRAME_BITS-1:0] lr_exp();
        logic [FRAME_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < FRAME_BITS; i++)
            v[FRAME_BITS-1-i] = (i >= SW - 1) && (i <= FRAME_BITS - 2);
        return v;
    endfunction

    // Reference model: pair buffer + frame boundary decision
    bit            mlf, mrf, ready_m;
    logic [AW-1:0] ml, mr;
    int            nxt;
    initial begin
        forever begin
            @(negedge clk);
            if (!running) begin
                mlf = 0;
                mrf = 0;
            end else begin
                nxt     = cyc + 1;
                ready_m = i_is_left ? !mlf : !mrf;
                if (i_valid) check("i_ready", i_ready, ready_m);
                if (nxt >= FIRST_FALL && (nxt - FIRST_FALL) % FRAME_CLKS == 0) begin
                    if (mlf && mrf) begin
                        exp_q.push_back('{l: ml, r: mr, uf: 1'b0});
                        mlf = 0;
                        mrf = 0;
                    end else begin
                        exp_q.push_back('{l: '0, r: '0, uf: 1'b1});
                    end
                end
                if (i_valid && ready_m) begin
                    if (i_is_left) begin ml = i_audio; mlf = 1; end
                    else           begin mr = i_audio; mrf = 1; end
                end
            end
        end
    end

    // Monitor: decode frames on rising sclk and compare against the queue
    int                    rise_idx, bi, ufc, frame_uf, first_rise, first_fall;
    bit                    sclk_prev;
    logic [FRAME_BITS-1:0] fr, lr;
    frame_t                e;
    initial begin
        forever begin
            @(negedge clk);
            if (!running) begin
                rise_idx = 0; sclk_prev = 0; ufc = 0; frame_uf = 0;
                fr = '0; lr = '0; first_rise = -1; first_fall = -1;
            end else begin
                if (o_underrun) ufc++;
                if (sclk && !sclk_prev) begin
                    if (first_rise < 0) first_rise = cyc;
                    if (rise_idx >= 1) begin
                        bi = (rise_idx - 1) % FRAME_BITS;
                        if (bi == 0) begin
                            frame_uf = ufc;
                            ufc = 0;
                        end
                        fr = {fr[FRAME_BITS-2:0], sdata};
                        lr = {lr[FRAME_BITS-2:0], lrclk};
                        if (bi == FRAME_BITS - 1) begin
                            frames_checked++;
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL frame_expect actual=frame_out required=none_queued");
                            end else begin
                                e = exp_q.pop_front();
                                check("frame_data", fr, {e.l, e.r});
                                check("frame_underrun", frame_uf, e.uf);
                                check("frame_lrclk", lr, lr_exp());
                            end
                        end
                    end
                    rise_idx++;
                end
                if (!sclk && sclk_prev && first_fall < 0) first_fall = cyc;
                sclk_prev = sclk;
            end
        end
    end

    // Capture of the first frame of the 12-bit instance
    int                    r12i, uf12c;
    bit                    p12;
    logic [FRAME_BITS-1:0] cap12, lr12;
    initial begin
        forever begin
            @(negedge clk);
            if (!running) begin
                r12i = 0; p12 = 0; uf12c = 0;
            end else begin
                if (uf12 && r12i <= FRAME_BITS) uf12c++;
                if (sclk12 && !p12) begin
                    if (r12i >= 1 && r12i <= FRAME_BITS) begin
                        cap12 = {cap12[FRAME_BITS-2:0], sdata12};
                        lr12  = {lr12[FRAME_BITS-2:0], lrclk12};
                    end
                    r12i++;
                end
                p12 = sclk12;
            end
        end
    end

    // Present one word (caller sits just after a posedge); returns just after the accepting edge
    task automatic send(input logic left, input logic [AW-1:0] d);
        int n;
        i_valid = 1'b1; i_is_left = left; i_audio = d; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 4 * FRAME_CLKS);
        if (!i_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [11:0]   r12;
    logic [AW-1:0] da, db;
    int            n;
    initial begin
        r12 = 12'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_underrun", o_underrun, 0);
        i_is_left = 1'b1; #1;
        check("rst_ready_left", i_ready, 1);
        i_is_left = 1'b0; #1;
        check("rst_ready_right", i_ready, 1);
        check("rst_ready12", rdy12, 1);

        // release, then one pair before the first falling sclk on both instances
        @(negedge clk); #1;
        reset_n = 1'b1; running = 1'b1;
        @(posedge clk); #1;
        i_valid = 1; i_is_left = 1; i_audio = 16'hA5A5;
        v12 = 1; t12 = 1; a12 = 12'hFFF;
        @(posedge clk); #1;
        i_is_left = 0; i_audio = 16'h0F0F;
        t12 = 0; a12 = r12;
        @(posedge clk); #1;
        i_valid = 0; v12 = 0;
        idle(FRAME_CLKS + 12);
        check("first_rise_clk", first_rise, BD);
        check("first_fall_clk", first_fall, 2 * BD);
        check("w12_slots", cap12, {12'hFFF, 4'h0, r12, 4'h0});
        check("w12_lrclk", lr12, lr_exp());
        check("w12_underrun", uf12c, 0);

        // silent frames
        idle(2 * FRAME_CLKS);

        // left only, stall a second left, then complete with right
        send(1'b1, 16'h8001);
        idle(FRAME_CLKS + 8);
        i_valid = 1; i_is_left = 1; i_audio = AW'($urandom);
        repeat (5) begin @(posedge clk); #1; end
        check("left_stall", i_ready, 0);
        send(1'b0, 16'h7FFE);
        idle(2 * FRAME_CLKS);

        // randomized stream, mostly back-to-back, occasionally starved
        for (int p = 0; p < 8; p++) begin
            da = AW'($urandom);
            db = AW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                send(1'b1, da); send(1'b0, db);
            end else begin
                send(1'b0, db); send(1'b1, da);
            end
            if (p % 3 == 2) idle($urandom_range(FRAME_CLKS, 2 * FRAME_CLKS));
            else            idle($urandom_range(0, 3));
        end
        idle(2 * FRAME_CLKS);

        // buffer a pair, then reset in the middle of bit 20
        n = 0;
        while (((cyc - FIRST_FALL) % FRAME_CLKS) != 10 && n < 2 * FRAME_CLKS) begin
            @(posedge clk); #1; n++;
        end
        send(1'b1, AW'($urandom));
        send(1'b0, AW'($urandom));
        i_valid = 0;
        n = 0;
        while (((cyc - FIRST_FALL) % FRAME_CLKS) != 4 * 20 + 1 && n < 2 * FRAME_CLKS) begin
            @(posedge clk); #1; n++;
        end
        check("midreset_reached", n < 2 * FRAME_CLKS, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_sclk", sclk, 0);
        check("midrst_lrclk", lrclk, 0);
        check("midrst_sdata", sdata, 0);
        check("midrst_underrun", o_underrun, 0);
        i_is_left = 1'b1; #1;
        check("midrst_ready_left", i_ready, 1);
        running = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1; running = 1'b1;
        idle(3 * FRAME_CLKS);

        check("queue_drained", exp_q.size() <= 1, 1);
        check("frames_seen", frames_checked >= 15, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
